// File: rtl/counter_sequencer_if.sv
// Control and status bundle between the push-button decoders, the LED pins
// and the counter_sequencer run controller.
//
// Handshake: there is no valid/ready pair here. START is a level request that
// the sequencer accepts on any rising edge where BUSY is low and STOP is low;
// while BUSY is high START is ignored. STOP is an unconditional abort level and
// HOLD is a freeze level. TICK and DONE are single-cycle strobes with no
// back-pressure, so a consumer must sample them on every edge.
interface counter_sequencer_if;
  logic       START;
  logic       STOP;
  logic       HOLD;
  logic       MODE;
  logic [3:0] COUNT_OUT;
  logic       DIRECTION;
  logic       TICK;
  logic       BUSY;
  logic       DONE;
  logic [7:0] CYCLE_CNT;

  // Button/controller side: drives requests, observes status.
  modport master (
    output START, STOP, HOLD, MODE,
    input  COUNT_OUT, DIRECTION, TICK, BUSY, DONE, CYCLE_CNT
  );

  // Sequencer side: consumes requests, drives status.
  modport slave (
    input  START, STOP, HOLD, MODE,
    output COUNT_OUT, DIRECTION, TICK, BUSY, DONE, CYCLE_CNT
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for the LED up/down counter: owns the tick prescaler and the
// 4-bit count, and runs either one up-sweep or a continuous bounce between
// LOW and HIGH with optional dwell ticks at each end.
module counter_sequencer #(
  parameter int         DIV         = 13500000,
  parameter logic [3:0] LOW         = 4'd0,
  parameter logic [3:0] HIGH        = 4'd15,
  parameter int         PAUSE_TICKS = 2
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  counter_sequencer_if.slave bus,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_PAUSE_HI = 3'd2,
    S_DOWN     = 3'd3,
    S_PAUSE_LO = 3'd4
  } state_t;

  localparam int              PW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam bit              NO_PAUSE   = (PAUSE_TICKS == 0);
  // Only consulted inside the dwell states, which are unreachable when NO_PAUSE.
  localparam logic [3:0]      PAUSE_LAST = NO_PAUSE ? 4'd0 : 4'(PAUSE_TICKS - 1);

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    pause_q;
  logic [3:0]    count_q;
  logic          dir_q;
  logic          tick_q;
  logic          done_q;
  logic          busy_q;
  logic          mode_q;
  logic [7:0]    cycle_q;
  logic          tick_now;

  // A tick is due on the edge where the prescaler sits at its last value.
  assign tick_now = (presc_q == PRESC_LAST);

  // Sequencer FSM: run control, prescaler, dwell counter and all registered outputs.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      pause_q <= 4'd0;
      count_q <= LOW;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      cycle_q <= 8'd0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        // START together with STOP is treated as a non-request.
        if (bus.START && !bus.STOP) begin
          state_q <= S_UP;
          presc_q <= '0;
          count_q <= LOW;
          dir_q   <= 1'b1;
          mode_q  <= bus.MODE;
          busy_q  <= 1'b1;
        end
      end else if (bus.STOP) begin
        // Abort beats both a coincident tick and HOLD; count and direction hold.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (!bus.HOLD) begin
        if (!tick_now) begin
          presc_q <= presc_q + 1'b1;
        end else begin
          presc_q <= '0;
          tick_q  <= 1'b1;
          // A bound-detecting tick only changes state, never the count.
          case (state_q)
            S_UP: begin
              if (count_q < HIGH) begin
                count_q <= count_q + 4'd1;
              end else if (!mode_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                dir_q   <= 1'b0;
                pause_q <= 4'd0;
                state_q <= NO_PAUSE ? S_DOWN : S_PAUSE_HI;
              end
            end
            S_PAUSE_HI: begin
              pause_q <= pause_q + 4'd1;
              if (pause_q == PAUSE_LAST) state_q <= S_DOWN;
            end
            S_DOWN: begin
              if (count_q > LOW) begin
                count_q <= count_q - 4'd1;
              end else begin
                dir_q   <= 1'b1;
                pause_q <= 4'd0;
                if (NO_PAUSE) begin
                  state_q <= S_UP;
                  cycle_q <= cycle_q + 8'd1;
                end else begin
                  state_q <= S_PAUSE_LO;
                end
              end
            end
            S_PAUSE_LO: begin
              pause_q <= pause_q + 4'd1;
              if (pause_q == PAUSE_LAST) begin
                state_q <= S_UP;
                cycle_q <= cycle_q + 8'd1;
              end
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.COUNT_OUT = count_q;
  assign bus.DIRECTION = dir_q;
  assign bus.TICK      = tick_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.CYCLE_CNT = cycle_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (dwell of 1 tick and no dwell)
// share one stimulus stream. A tick-script reference model predicts the
// outputs after each edge; monitors compare them one edge later.
module tb_counter_sequencer;

  localparam int DIV  = 4;
  localparam int LOW  = 2;
  localparam int HIGH = 5;
  localparam int R    = HIGH - LOW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer_if bus1 ();
  counter_sequencer_if bus0 ();
  logic [2:0] dbg1, dbg0;

  counter_sequencer #(.DIV(DIV), .LOW(4'(LOW)), .HIGH(4'(HIGH)), .PAUSE_TICKS(1)) dut_p1 (
    .CLOCK(clk), .RESET_N(rst_n), .bus(bus1), .dbg_state_o(dbg1)
  );
  counter_sequencer #(.DIV(DIV), .LOW(4'(LOW)), .HIGH(4'(HIGH)), .PAUSE_TICKS(0)) dut_p0 (
    .CLOCK(clk), .RESET_N(rst_n), .bus(bus0), .dbg_state_o(dbg0)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit         busy;
    bit         mode;
    logic [3:0] count;
    bit         dir;
    bit         tick;
    bit         done;
    logic [7:0] cyc;
    int         phase;  // non-held run cycles since the last tick
    int         pos;    // ticks taken within the current sweep/period
  } model_t;

  model_t m1, m0;

  // What the k-th tick of a run (1-based, within one period) produces.
  function automatic void script(input int p, input bit bounce, input int k,
                                 output logic [3:0] c, output bit d,
                                 output bit fin, output bit cinc);
    fin  = 1'b0;
    cinc = 1'b0;
    if (!bounce) begin
      if (k <= R) begin c = 4'(LOW + k); d = 1'b1; end
      else begin c = 4'(HIGH); d = 1'b1; fin = 1'b1; end
    end else if (k <= R) begin
      c = 4'(LOW + k); d = 1'b1;
    end else if (k <= R + 1 + p) begin
      c = 4'(HIGH); d = 1'b0;
    end else if (k <= 2 * R + 1 + p) begin
      c = 4'(HIGH - (k - (R + 1 + p))); d = 1'b0;
    end else begin
      c = 4'(LOW); d = 1'b1;
      cinc = (k == 2 * (R + 1 + p));
    end
  endfunction

  function automatic model_t mstep(input model_t m, input int p, input bit r,
                                   input bit st, input bit sp, input bit hd, input bit md);
    model_t n;
    int k;
    logic [3:0] c;
    bit d, fin, cinc;
    n = m;
    n.tick = 1'b0;
    n.done = 1'b0;
    if (!r) begin
      n.busy = 1'b0; n.mode = 1'b0; n.count = 4'(LOW); n.dir = 1'b1;
      n.cyc = 8'd0; n.phase = 0; n.pos = 0;
    end else if (!m.busy) begin
      if (st && !sp) begin
        n.busy = 1'b1; n.mode = md; n.count = 4'(LOW); n.dir = 1'b1;
        n.phase = 0; n.pos = 0;
      end
    end else if (sp) begin
      n.busy = 1'b0;
    end else if (!hd) begin
      n.phase = m.phase + 1;
      if (n.phase == DIV) begin
        n.phase = 0;
        n.tick  = 1'b1;
        k = m.pos + 1;
        script(p, m.mode, k, c, d, fin, cinc);
        n.count = c;
        n.dir   = d;
        if (fin) begin n.done = 1'b1; n.busy = 1'b0; end
        if (cinc) n.cyc = m.cyc + 8'd1;
        n.pos = k % (2 * (R + 1 + p));
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] pack_m(input model_t m);
    return {m.count, m.dir, m.tick, m.busy, m.done, m.cyc};
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q0[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  // ---------------- driver tasks ----------------
  task automatic step(input bit r, input bit st, input bit sp, input bit hd, input bit md);
    @(negedge clk);
    cyc_no++;
    rst_n = r;
    bus1.START = st; bus1.STOP = sp; bus1.HOLD = hd; bus1.MODE = md;
    bus0.START = st; bus0.STOP = sp; bus0.HOLD = hd; bus0.MODE = md;
    m1 = mstep(m1, 1, r, st, sp, hd, md);
    m0 = mstep(m0, 0, r, st, sp, hd, md);
    exp_q1.push_back(pack_m(m1));
    exp_q0.push_back(pack_m(m0));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitors ----------------
  logic [15:0] e1, a1, e0, a0;

  always @(posedge clk) begin
    #1;
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      a1 = {bus1.COUNT_OUT, bus1.DIRECTION, bus1.TICK, bus1.BUSY, bus1.DONE, bus1.CYCLE_CNT};
      n_cmp++;
      if (a1 !== e1) begin
        n_err++;
        $display("FAIL pause1_outputs cycle %0d: got cnt=%0d dir=%0b tick=%0b busy=%0b done=%0b cyc=%0d, want cnt=%0d dir=%0b tick=%0b busy=%0b done=%0b cyc=%0d",
                 cyc_no, a1[15:12], a1[11], a1[10], a1[9], a1[8], a1[7:0],
                 e1[15:12], e1[11], e1[10], e1[9], e1[8], e1[7:0]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      a0 = {bus0.COUNT_OUT, bus0.DIRECTION, bus0.TICK, bus0.BUSY, bus0.DONE, bus0.CYCLE_CNT};
      n_cmp++;
      if (a0 !== e0) begin
        n_err++;
        $display("FAIL pause0_outputs cycle %0d: got cnt=%0d dir=%0b tick=%0b busy=%0b done=%0b cyc=%0d, want cnt=%0d dir=%0b tick=%0b busy=%0b done=%0b cyc=%0d",
                 cyc_no, a0[15:12], a0[11], a0[10], a0[9], a0[8], a0[7:0],
                 e0[15:12], e0[11], e0[10], e0[9], e0[8], e0[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit st, hd;
    bus1.START = 1'b0; bus1.STOP = 1'b0; bus1.HOLD = 1'b0; bus1.MODE = 1'b0;
    bus0.START = 1'b0; bus0.STOP = 1'b0; bus0.HOLD = 1'b0; bus0.MODE = 1'b0;

    // reset held for 3 edges with random inputs
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(2);

    // single sweep: DONE at edge 16, count held at HIGH
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    // bounce: full period and into the next one
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(60);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // STOP on the edge-8 tick
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // START while busy is ignored, then stop
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // START and STOP together in IDLE
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);

    // HOLD over edges 5-9, then reset during DOWN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // randomized traffic
    repeat (3000) begin
      hd = ($urandom_range(0, 5) == 0);
      st = !hd && ($urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 199) != 0), st, 1'($urandom_range(0, 39) == 0),
           hd, 1'($urandom_range(0, 1)));
    end

    // drain
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q1.size() + exp_q0.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q1.size() + exp_q0.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run controller for the LED up/down counter path. It owns the tick prescaler and the 4-bit count register, and sequences the count through programmable sweeps:
- single up-sweep, or
- continuous up/down bounce with dwell pauses at each end.

It sits between the board push-button decoders (START/STOP/HOLD) and the LED pins, and reports run status and completed cycles.

## Interface
Parameters:
- DIV, 13500000: clock cycles per count tick; legal range ≥ 2.
- LOW, 0: lower count bound, 4-bit.
- HIGH, 15: upper count bound, 4-bit. LOW < HIGH is required.
- PAUSE_TICKS, 2: dwell ticks at each end in bounce mode, 0–15. 0 means no dwell.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  level sampled each edge; accepted only in IDLE.
- STOP  in  1  abort run; overrides everything except reset.
- HOLD  in  1  freeze prescaler, count and state while high.
- MODE  in  1  0 = single sweep, 1 = bounce; latched when START is accepted.
- COUNT_OUT  out  4  current count.
- DIRECTION  out  1  1 = counting up, 0 = counting down.
- TICK  out  1  one-cycle pulse, registered, for each prescaler tick taken in a run state.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a single sweep completes.
- CYCLE_CNT  out  8  number of completed bounce cycles, wraps 255→0.

## Operation
- States: IDLE, UP, PAUSE_HI, DOWN, PAUSE_LO.
- Reset (RESET_N low at an edge) sets the following. Reset wins over all inputs, including mid-run.
  - state = IDLE, COUNT_OUT = LOW, DIRECTION = 1.
  - TICK = DONE = BUSY = 0, CYCLE_CNT = 0, prescaler = 0, pause counter = 0, latched mode = 0.
- IDLE:
  - COUNT_OUT and DIRECTION hold their values.
  - START = 1 and STOP = 0 loads COUNT_OUT = LOW, DIRECTION = 1, prescaler = 0, latches MODE, and moves to UP.
  - CYCLE_CNT is not cleared by START.
- Tick: in a run state with HOLD = 0, the prescaler increments each edge. At an edge where prescaler = DIV−1, the prescaler returns to 0 and a tick is taken. All state and count actions below occur only on tick edges.
- UP:
  - COUNT_OUT < HIGH: increment.
  - COUNT_OUT = HIGH, single mode: pulse DONE and go to IDLE. COUNT_OUT stays HIGH.
  - COUNT_OUT = HIGH, bounce mode: DIRECTION ← 0. Go to PAUSE_HI with pause counter = 0, or straight to DOWN if PAUSE_TICKS = 0.
- PAUSE_HI: each tick increments the pause counter. On the tick where the counter = PAUSE_TICKS−1, go to DOWN. The count does not change.
- DOWN:
  - COUNT_OUT > LOW: decrement.
  - COUNT_OUT = LOW: DIRECTION ← 1. Go to PAUSE_LO, or straight to UP if PAUSE_TICKS = 0. In the PAUSE_TICKS = 0 case, CYCLE_CNT increments here.
- PAUSE_LO: same dwell rule as PAUSE_HI. On exit to UP, CYCLE_CNT increments.
- The tick that detects a bound changes state only; it never changes the count. The count never leaves [LOW, HIGH].
- STOP = 1 in a run state: go to IDLE at that edge.
  - COUNT_OUT and DIRECTION hold, no DONE pulse.
  - STOP beats a simultaneous tick or HOLD.
- START while BUSY is ignored. START and STOP together in IDLE: stay in IDLE.
- HOLD = 1: prescaler, pause counter, count and state all freeze, and no TICK is issued. STOP is still honoured.

## Timing
- Let edge 0 be the edge at which START is accepted. Ticks then occur at edges DIV, 2·DIV, …, provided there is no HOLD.
- A HOLD of h cycles delays all later ticks by h.
- TICK, DONE, COUNT_OUT, DIRECTION and CYCLE_CNT all update on the same edge as the tick that causes them. TICK and DONE are high for exactly one cycle.
- BUSY rises the cycle after edge 0 and falls the cycle after the edge that enters IDLE.
- Bounce period is 2·(HIGH−LOW+1+PAUSE_TICKS) ticks.

## Test plan
All scenarios use DIV=4, LOW=2, HIGH=5, PAUSE_TICKS=1 unless stated.

- **Reset:** hold RESET_N low for 3 edges with random inputs → COUNT_OUT=2, DIRECTION=1, BUSY=TICK=DONE=0, CYCLE_CNT=0.
- **Single sweep:** MODE=0, START pulsed at edge 0.
  - COUNT_OUT=2 after edge 0, then 3/4/5 at edges 4/8/12.
  - DONE pulses at edge 16, then BUSY=0 with COUNT_OUT held at 5.
- **Bounce:** MODE=1.
  - Count reaches 5 at edge 12.
  - Edge 16: enter PAUSE_HI, DIRECTION=0.
  - Edge 20: enter DOWN.
  - COUNT_OUT=4/3/2 at edges 24/28/32.
  - Edge 36: enter PAUSE_LO, DIRECTION=1.
  - Edge 40: enter UP, CYCLE_CNT=1.
  - Edge 44: COUNT_OUT=3.
- **PAUSE_TICKS=0 bounce:** DOWN entered at edge 16 (DIRECTION=0). UP re-entered at edge 32 with CYCLE_CNT=1. Across 200 cycles, COUNT_OUT never repeats a bound except at reversal.
- **STOP and START priority:**
  - STOP coincident with the edge-8 tick → IDLE, COUNT_OUT=3, no DONE.
  - A further START while BUSY is ignored.
  - START+STOP together in IDLE keep IDLE.
- **HOLD and reset mid-run:**
  - HOLD high over edges 5–9 shifts the next tick from edge 8 to edge 13, and no TICK fires during the hold.
  - RESET_N low during DOWN returns all outputs to their reset values on that edge.
